alu_arbiter_2req: RTL and testbench
===================================

// Module: alu_arbiter_2req
// PURPOSE
//  Shares one combinational ALU_32bit between two requesters using valid/ready handshakes.
//  - Round-robin arbitration.
//  - Registered operands and registered result, so the ALU sits between two register stages.
//  - The result returns with the requester ID and ALU flags under res_valid/res_ready backpressure.
//  - Sits between issuing units (e.g. decode, address-gen) and the shared ALU_32bit datapath.
// PARAMETERS
//  WIDTH  32  operand/result width; fixed to the ALU_32bit width
//  CNT_W  16  width of the completed-operation counter
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  req0_valid    in   1      requester 0 has an operation
//  req0_ready    out  1      requester 0 operation accepted this cycle
//  req0_f        in   3      requester 0 ALU function
//  req0_a        in   WIDTH  requester 0 operand A
//  req0_b        in   WIDTH  requester 0 operand B
//  req1_valid    in   1      requester 1 has an operation
//  req1_ready    out  1      requester 1 operation accepted this cycle
//  req1_f        in   3      requester 1 ALU function
//  req1_a        in   WIDTH  requester 1 operand A
//  req1_b        in   WIDTH  requester 1 operand B
//  res_valid     out  1      result registers hold a valid result
//  res_ready     in   1      consumer accepts the result
//  res_id        out  1      requester that issued the result
//  res_y         out  WIDTH  ALU result Y
//  res_zero      out  1      ALU Zero flag
//  res_overflow  out  1      ALU Overflow flag
//  res_err       out  1      illegal function code (F=3'b100)
//  busy          out  1      state != IDLE
//  op_count      out  CNT_W  completed result handshakes; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (synchronous, one cycle):
//  - state=IDLE, rr_last=1 (req0 wins first contention), op_count=0.
//  - All res_* outputs=0, req*_ready=0, busy=0.
//  - Reset mid-operation discards the operation. No ready pulse and no result is produced for it.
//  F encoding (ALU_32bit): 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011/101 passed through.
//  F=100 is illegal.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//  - IDLE:
//    - If any reqN_valid, grant one requester and assert its reqN_ready combinationally, only in IDLE.
//    - On that edge, capture f/a/b and id into the operand regs, set rr_last=id, go to EXEC.
//  - EXEC:
//    - ALU driven from the operand regs.
//    - Capture Y/Zero/Overflow into the result regs and go to RESP.
//    - If F==100, capture Y=0, Zero=0, Overflow=0, err=1 instead.
//  - RESP:
//    - res_valid=1. All res_* outputs held stable until res_valid&res_ready.
//    - On that handshake: op_count+=1, res_valid drops, go to IDLE.
//    - No request is accepted in the handshake cycle.
//  Latency and throughput:
//  - Accept at edge N gives res_valid from cycle N+2.
//  - Minimum issue interval is 3 cycles.
//  Arbitration:
//  - Only one requester valid: that requester is granted.
//  - Both valid: grant !rr_last.
//  - Grant is recomputed every IDLE cycle. No state is held for unaccepted requests.
//  Requester rules:
//  - Requesters hold valid and operands until ready.
//  - The block does not require this; a withdrawn request is simply not granted.
//  Never true: req0_ready & req1_ready in the same cycle.
//  Never asserted: reqN_ready outside IDLE.
// STRUCTURE
//  Shared package alu_ctrl_pkg holds:
//  - F code constants (F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_ILLEGAL=3'b100).
//  - State typedef {IDLE, EXEC, RESP}.
//  Sub-modules:
//  - rr_arbiter_2: combinational grant from valid[1:0], rr_last and enable.
//  - The existing ALU_32bit is instantiated unchanged.
// TESTING
//  Single add:
//  - req0 F=010 A=5 B=7, res_ready=1.
//  - Expect req0_ready 1 cycle, res_valid at N+2, Y=12, id=0, Zero=0, Ovf=0, op_count=1.
//  Contention:
//  - Both valid continuously, req0 F=110 A=3 B=3, req1 F=000 A=F0F0F0F0 B=0FF00FF0.
//  - Expect grant order 0,1,0,1.
//  - Expect Y=0/Zero=1 (id 0) and Y=00F000F0/Zero=0 (id 1).
//  Overflow and SLT:
//  - req1 F=010 A=7FFFFFFF B=1 -> Y=80000000, Ovf=1.
//  - Then F=111 A=FFFFFFFF B=1 -> Y=1.
//  Backpressure and illegal F:
//  - res_ready=0 for 5 cycles -> res_* stable, busy=1, no reqN_ready.
//  - F=100 -> err=1, Y=0.
//  Reset mid-op:
//  - Assert reset in EXEC and again in RESP.
//  - Expect next cycle: IDLE, res_valid=0, op_count=0, and req0 wins the next contention.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the two-requester ALU front end.
// F codes follow the ALU_32bit encoding.
package alu_ctrl_pkg;
   localparam logic [2:0] F_AND     = 3'b000;
   localparam logic [2:0] F_OR      = 3'b001;
   localparam logic [2:0] F_ADD     = 3'b010;
   localparam logic [2:0] F_SUB     = 3'b110;
   localparam logic [2:0] F_SLT     = 3'b111;
   localparam logic [2:0] F_ILLEGAL = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/ALU_32bit.sv
// Existing 32-bit ALU: F[2] inverts B, F[1:0] picks AND/OR/SUM/SLT.
// Purely combinational.
module ALU_32bit (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  F,
   output logic [31:0] Y,
   output logic        Zero,
   output logic        Overflow
);
   logic [31:0] w_bb;
   logic [31:0] w_s;
   logic        w_v;

   assign w_bb = F[2] ? ~B : B;
   assign w_s  = A + w_bb + {31'b0, F[2]};
   assign w_v  = (A[31] == w_bb[31]) & (w_s[31] != A[31]);

   always_comb begin
      Y = '0;
      unique case (F[1:0])
         2'b00:   Y = A & w_bb;
         2'b01:   Y = A | w_bb;
         2'b10:   Y = w_s;
         default: Y = {31'b0, w_s[31] ^ w_v};
      endcase
   end

   assign Overflow = (F[1:0] == 2'b10) & w_v;
   assign Zero     = (Y == 32'b0);
endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; i_rr_last is the last winner.
// Grants are one-hot and only issued while enabled.
module rr_arbiter_2 (
   input  logic [1:0] i_valid,
   input  logic       i_rr_last,
   input  logic       i_en,
   output logic [1:0] o_grant
);
   assign o_grant[0] = i_en & i_valid[0] & (~i_valid[1] | i_rr_last);
   assign o_grant[1] = i_en & i_valid[1] & (~i_valid[0] | ~i_rr_last);
endmodule

// File: rtl/alu_arbiter_2req.sv
// Shares one ALU_32bit between two valid/ready requesters, round-robin,
// with registered operands and a registered, back-pressured result.
module alu_arbiter_2req
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_f,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_f,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [WIDTH-1:0] res_y,
   output logic             res_zero,
   output logic             res_overflow,
   output logic             res_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   state_t           r_state;
   state_t           w_next;
   logic             r_rr_last;
   logic [2:0]       r_f;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_id;
   logic [WIDTH-1:0] r_y;
   logic             r_zero;
   logic             r_ovf;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       w_gnt;
   logic             w_en;
   logic             w_acc;
   logic             w_hs;
   logic [WIDTH-1:0] w_y;
   logic             w_zero;
   logic             w_ovf;

   // Reset also masks the grant so no ready leaks out in the reset cycle.
   assign w_en  = (r_state == IDLE) & ~reset;
   assign w_acc = |w_gnt;
   assign w_hs  = (r_state == RESP) & res_ready;

   rr_arbiter_2 u_arb (
      .i_valid   ({req1_valid, req0_valid}),
      .i_rr_last (r_rr_last),
      .i_en      (w_en),
      .o_grant   (w_gnt)
   );

   ALU_32bit u_alu (
      .A        (r_a),
      .B        (r_b),
      .F        (r_f),
      .Y        (w_y),
      .Zero     (w_zero),
      .Overflow (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_acc) w_next = EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_last <= 1'b1;
         r_f       <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_id      <= 1'b0;
         r_y       <= '0;
         r_zero    <= 1'b0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_acc) begin
            r_f       <= w_gnt[1] ? req1_f : req0_f;
            r_a       <= w_gnt[1] ? req1_a : req0_a;
            r_b       <= w_gnt[1] ? req1_b : req0_b;
            r_id      <= w_gnt[1];
            r_rr_last <= w_gnt[1];
         end
         if (r_state == EXEC) begin
            if (r_f == F_ILLEGAL) begin
               r_y    <= '0;
               r_zero <= 1'b0;
               r_ovf  <= 1'b0;
               r_err  <= 1'b1;
            end else begin
               r_y    <= w_y;
               r_zero <= w_zero;
               r_ovf  <= w_ovf;
               r_err  <= 1'b0;
            end
         end
         if (w_hs) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign req0_ready   = w_gnt[0];
   assign req1_ready   = w_gnt[1];
   assign res_valid    = (r_state == RESP);
   assign res_id       = r_id;
   assign res_y        = r_y;
   assign res_zero     = r_zero;
   assign res_overflow = r_ovf;
   assign res_err      = r_err;
   assign busy         = (r_state != IDLE);
   assign op_count     = r_cnt;
endmodule

// File: tb/tb_alu_arbiter_2req.sv
// Directed bench for alu_arbiter_2req: grants, latency, results,
// backpressure, illegal F and reset mid-operation.
module tb_alu_arbiter_2req;
   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [2:0]  req0_f;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [2:0]  req1_f;
   logic [31:0] req1_a, req1_b;
   logic        res_valid, res_ready, res_id;
   logic [31:0] res_y;
   logic        res_zero, res_overflow, res_err, busy;
   logic [15:0] op_count;

   int n_chk = 0;
   int n_err = 0;
   int exp_cnt = 0;
   int cyc = 0;

   alu_arbiter_2req dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_f       (req0_f),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_f       (req1_f),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_id       (res_id),
      .res_y        (res_y),
      .res_zero     (res_zero),
      .res_overflow (res_overflow),
      .res_err      (res_err),
      .busy         (busy),
      .op_count     (op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int id, input logic v, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b);
      if (id == 0) begin
         req0_valid = v; req0_f = f; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_f = f; req1_a = a; req1_b = b;
      end
   endtask

   // Called just after a negedge; returns granted id or -1 on timeout.
   task automatic wait_grant(output int gid);
      gid = -1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (req0_ready | req1_ready) begin
            chk("one_hot", 32'(req0_ready & req1_ready), 32'd0);
            gid = req1_ready ? 1 : 0;
            return;
         end
         @(negedge clk);
      end
      chk("grant_timeout", 32'd1, 32'd0);
   endtask

   task automatic check_res(input string tag, input logic id,
                            input logic [31:0] y, input logic z,
                            input logic o, input logic e);
      chk({tag, "_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_id"}, 32'(res_id), 32'(id));
      chk({tag, "_y"}, res_y, y);
      chk({tag, "_zero"}, 32'(res_zero), 32'(z));
      chk({tag, "_ovf"}, 32'(res_overflow), 32'(o));
      chk({tag, "_err"}, 32'(res_err), 32'(e));
   endtask

   task automatic run_op(input string tag, input int id, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] y, input logic z,
                         input logic o, input logic e);
      int g;
      @(negedge clk);
      set_req(id, 1'b1, f, a, b);
      wait_grant(g);
      chk({tag, "_gnt"}, 32'(g), 32'(id));
      @(negedge clk);
      set_req(id, 1'b0, 3'b0, 32'b0, 32'b0);
      chk({tag, "_exec_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      check_res(tag, 1'(id), y, z, o, e);
      @(negedge clk);
      exp_cnt++;
      chk({tag, "_done_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
   endtask

   initial begin
      int g;
      int last_cyc;
      reset = 1'b1;
      res_ready = 1'b1;
      set_req(0, 1'b1, 3'b010, 32'd1, 32'd2);
      set_req(1, 1'b0, 3'b0, 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(op_count), 32'd0);
      chk("rst_y", res_y, 32'd0);
      set_req(0, 1'b0, 3'b0, 32'd0, 32'd0);
      reset = 1'b0;

      run_op("add", 0, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
      run_op("ovf", 1, 3'b010, 32'h7FFF_FFFF, 32'd1,
             32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_op("slt", 1, 3'b111, 32'hFFFF_FFFF, 32'd1,
             32'd1, 1'b0, 1'b0, 1'b0);

      // Contention: rr_last is 1 here, so req0 should lead.
      @(negedge clk);
      set_req(0, 1'b1, 3'b110, 32'd3, 32'd3);
      set_req(1, 1'b1, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      last_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         chk("cont_order", 32'(g), 32'(k % 2));
         if (k > 0) chk("cont_interval", 32'(cyc - last_cyc), 32'd3);
         last_cyc = cyc;
         @(negedge clk);
         if (k == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         @(negedge clk);
         if (k % 2 == 0) check_res("cont0", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
         else check_res("cont1", 1'b1, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
         exp_cnt++;
         @(negedge clk);
      end
      chk("cont_cnt", 32'(op_count), 32'(exp_cnt));

      // Backpressure with an illegal function code.
      res_ready = 1'b0;
      set_req(0, 1'b1, 3'b100, 32'h1234, 32'h5678);
      wait_grant(g);
      chk("bp_gnt", 32'(g), 32'd0);
      @(negedge clk);
      set_req(0, 1'b0, 3'b0, 32'd0, 32'd0);
      set_req(1, 1'b1, 3'b001, 32'h0F, 32'hF0);
      #1 chk("bp_exec_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         check_res("bp", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_rdy1", 32'(req1_ready), 32'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      #1 chk("bp_hs_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      exp_cnt++;
      set_req(1, 1'b0, 3'b0, 32'd0, 32'd0);
      chk("bp_cnt", 32'(op_count), 32'(exp_cnt));

      // Reset while in EXEC.
      run_op("pre", 0, 3'b001, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      set_req(0, 1'b1, 3'b010, 32'd1, 32'd1);
      wait_grant(g);
      @(negedge clk);
      set_req(0, 1'b0, 3'b010, 32'd1, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 0;
      chk("rex_busy", 32'(busy), 32'd0);
      chk("rex_valid", 32'(res_valid), 32'd0);
      chk("rex_cnt", 32'(op_count), 32'd0);
      set_req(0, 1'b1, 3'b010, 32'd1, 32'd1);
      set_req(1, 1'b1, 3'b010, 32'd9, 32'd9);
      wait_grant(g);
      chk("rex_gnt", 32'(g), 32'd0);

      // Reset while in RESP.
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      chk("rrs_pre_valid", 32'(res_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      res_ready = 1'b1;
      chk("rrs_busy", 32'(busy), 32'd0);
      chk("rrs_valid", 32'(res_valid), 32'd0);
      chk("rrs_y", res_y, 32'd0);
      chk("rrs_cnt", 32'(op_count), 32'd0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      wait_grant(g);
      chk("rrs_gnt", 32'(g), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check_res("rrs_res", 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      exp_cnt++;
      chk("rrs_cnt_after", 32'(op_count), 32'(exp_cnt));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
